// File: rtl/dram_burst_reader_if.sv
// Handshake bundle for dram_burst_reader: command channel, DRAM read port and output stream.
// cmd_stride exists only when DRAM_RD_STRIDE_EN is defined.
interface dram_burst_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 12
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [LEN_WIDTH-1:0]  cmd_len;
`ifdef DRAM_RD_STRIDE_EN
    logic [ADDR_WIDTH-1:0] cmd_stride;
`endif
    logic                  en_rd;
    logic [ADDR_WIDTH-1:0] addr_rd;
    logic                  dram_valid;
    logic [DATA_WIDTH-1:0] dram_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;

    // Reader side
    modport slave (
`ifdef DRAM_RD_STRIDE_EN
        input  cmd_stride,
`endif
        input  cmd_valid, cmd_base, cmd_len, dram_valid, dram_data, out_ready,
        output cmd_ready, en_rd, addr_rd, out_valid, out_data, out_last, busy, done
    );

    // Controller / DRAM model / sink side
    modport master (
`ifdef DRAM_RD_STRIDE_EN
        output cmd_stride,
`endif
        output cmd_valid, cmd_base, cmd_len, dram_valid, dram_data, out_ready,
        input  cmd_ready, en_rd, addr_rd, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/dram_burst_reader.sv
// Burst read master: one DRAM read per word, credit-limited so returns always fit the FIFO.
// Optional strided addressing is enabled by defining DRAM_RD_STRIDE_EN.
module dram_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int LEN_WIDTH  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                srstn,
    dram_burst_reader_if.slave  bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]        DEPTH_V  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]      PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]  remaining_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  delivered_r;
    logic                  cmd_ready_r;
    logic                  en_rd_r;
    logic [ADDR_WIDTH-1:0] addr_rd_r;
    logic                  busy_r;
    logic                  done_r;

    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      outstanding_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] step_s;
    logic [CNT_W:0]        credit_s;
    logic                  issue_s;
    logic                  accept_s;
    logic                  ret_s;
    logic                  out_valid_s;
    logic                  pop_s;
    logic                  last_s;
    logic                  finish_s;

`ifdef DRAM_RD_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_r;

    // Latch the per-burst address stride at command acceptance
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            stride_r <= '0;
        end else if (state_r == ST_IDLE && accept_s) begin
            stride_r <= bus.cmd_stride;
        end else begin
            stride_r <= stride_r;
        end
    end

    assign step_s = stride_r;
`else
    assign step_s = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

    // Words in the FIFO plus words in flight must never exceed the FIFO size
    assign credit_s    = {1'b0, count_r} + {1'b0, outstanding_r};
    assign issue_s     = (state_r == ST_ISSUE) && (remaining_r != '0) && (credit_s < DEPTH_V);
    assign accept_s    = bus.cmd_valid && cmd_ready_r;
    assign ret_s       = bus.dram_valid && (outstanding_r != '0);
    assign out_valid_s = (count_r != '0);
    assign pop_s       = out_valid_s && bus.out_ready;
    assign last_s      = out_valid_s && (delivered_r == (len_r - LEN_ONE));
    assign finish_s    = (state_r == ST_DRAIN) && pop_s && last_s;

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.en_rd     = en_rd_r;
    assign bus.addr_rd   = addr_rd_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = out_valid_s ? mem_r[rd_ptr_r] : '0;
    assign bus.out_last  = last_s;

    // Burst control FSM with registered command, request and status outputs
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            remaining_r <= '0;
            len_r       <= '0;
            delivered_r <= '0;
            cmd_ready_r <= 1'b0;
            en_rd_r     <= 1'b0;
            addr_rd_r   <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            en_rd_r   <= 1'b0;
            addr_rd_r <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (bus.cmd_len != '0)) begin
                        addr_r      <= bus.cmd_base;
                        remaining_r <= bus.cmd_len;
                        len_r       <= bus.cmd_len;
                        delivered_r <= '0;
                        busy_r      <= 1'b1;
                        cmd_ready_r <= 1'b0;
                        state_r     <= ST_ISSUE;
                    end else if (accept_s) begin
                        done_r      <= 1'b1;
                        cmd_ready_r <= 1'b1;
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (issue_s) begin
                        en_rd_r     <= 1'b1;
                        addr_rd_r   <= addr_r;
                        addr_r      <= addr_r + step_s;
                        remaining_r <= remaining_r - LEN_ONE;
                        if (remaining_r == LEN_ONE) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_ISSUE;
                        end
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DRAIN: begin
                    if (finish_s) begin
                        state_r     <= ST_IDLE;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        cmd_ready_r <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    cmd_ready_r <= 1'b0;
                end
            endcase
            // The FIFO is always empty in IDLE, so this never collides with the clear above
            if (pop_s) begin
                delivered_r <= delivered_r + LEN_ONE;
            end
        end
    end

    // Return FIFO and in-flight request accounting; stale returns are ignored
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            outstanding_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (ret_s) begin
                mem_r[wr_ptr_r] <= bus.dram_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r       <= count_r + CNT_W'(ret_s) - CNT_W'(pop_s);
            outstanding_r <= outstanding_r + CNT_W'(issue_s) - CNT_W'(ret_s);
        end
    end
endmodule
